ls_mem_port: RTL

- Memory-side stage directly downstream of the LS tile.
- Accepts one decoded load/store request at a time (13-bit control word plus store data), performs it against a local x_memory × y_memory word array after a fixed access latency, and returns one response per request.
- Load responses carry the word that feeds the LS tile's memory-read register.
- Store data is taken from the LS tile's memory-write register.

---
 rtl/ls_mem_port_if.sv | 28 ++
 rtl/ls_mem_port.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ls_mem_port_if.sv
// ls_mem_port_if: request/response handshake bundle between the LS tile and its memory port.
`default_nettype none

interface ls_mem_port_if #(
    parameter int ctrl_width = 13,
    parameter int data_width = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ctrl_width-1:0] req_ctrl;
    logic [data_width-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [data_width-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_ctrl, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_ctrl, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/ls_mem_port.sv
//------------------------------------------------------------------------------
// Module  : ls_mem_port
// Brief   : Single-outstanding load/store port onto a local x_memory x y_memory
//           word array with fixed access latency. LS_MEM_BOUNDS_EN adds range check.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ls_mem_port #(
    parameter int ctrl_width  = 13,
    parameter int data_width  = 32,
    parameter int x_memory    = 64,
    parameter int y_memory    = 64,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ls_mem_port_if.slave      bus,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int ROW_W = (x_memory > 1) ? $clog2(x_memory) : 1;
    localparam int COL_W = (y_memory > 1) ? $clog2(y_memory) : 1;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [ctrl_width-1:0] r_ctrl;
    logic [data_width-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic [data_width-1:0] r_rdata;
    logic                  r_err;

    logic [data_width-1:0] r_mem [x_memory][y_memory];

    logic                  w_accept;
    logic                  w_done;
    logic [5:0]            w_addr;
    logic [5:0]            w_off;
    logic                  w_store;
    logic [ROW_W-1:0]      w_row;
    logic [COL_W-1:0]      w_col;
    logic                  w_in_range;
    logic [data_width-1:0] w_rd_word;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_done   = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_store  = r_ctrl[0];
    assign w_addr   = r_ctrl[6:1];
    assign w_off    = r_ctrl[12:7];
    assign w_row    = w_addr[ROW_W-1:0];
    assign w_col    = w_off[COL_W-1:0];

`ifdef LS_MEM_BOUNDS_EN
    assign w_in_range = (32'(w_addr) < x_memory) && (32'(w_off) < y_memory);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_rd_word = r_mem[w_row][w_col];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req_valid) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == '0)   w_next = S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
            end
            S_RESP:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctrl  <= bus.req_ctrl;
                r_wdata <= bus.req_wdata;
                r_cnt   <= CNT_W'(MEM_LATENCY - 1);
            end else if ((r_state == S_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done) begin
                r_rdata <= (!w_store && w_in_range) ? w_rd_word : '0;
                r_err   <= !w_in_range;
            end
        end
    end

    // Storage has no reset; a store caught by reset in ACCESS is dropped
    always_ff @(posedge clk) begin
        if (!reset && w_done && w_store && w_in_range) begin
            r_mem[w_row][w_col] <= r_wdata;
        end
    end

endmodule

`default_nettype wire
